pipe_axi_arbiter: RTL and testbench
===================================

Name: pipe_axi_arbiter

Overview:
- Shares the single AXI-Lite memory port between the IFU (read-only master) and the LSU (read/write master). One transaction is in flight at a time.
- Chooses one owner, steers the valid/ready handshakes and the read address to that owner, and returns to idle once the response handshake completes.
- Data and write-payload buses are wired at top level: mem rdata goes to both masters; LSU awaddr/wdata/wstrb go straight to mem. Only handshakes and araddr pass through this block.

Parameters:
- ADDR_WIDTH, 32, address width of the AR channels.
- RESET_PRIO, 0, owner that wins the first IFU/LSU tie after reset (0=IFU, 1=LSU).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ifu_araddr_i  in  ADDR_WIDTH  IFU read address
- ifu_arvalid_i  in  1  IFU read request
- ifu_arready_o  out  1  AR accept to IFU
- ifu_rvalid_o  out  1  read data valid to IFU
- ifu_rready_i  in  1  IFU ready for read data
- lsu_araddr_i  in  ADDR_WIDTH  LSU read address
- lsu_arvalid_i  in  1  LSU read request
- lsu_arready_o  out  1  AR accept to LSU
- lsu_rvalid_o  out  1  read data valid to LSU
- lsu_rready_i  in  1  LSU ready for read data
- lsu_awvalid_i  in  1  LSU write address valid
- lsu_awready_o  out  1  AW accept to LSU
- lsu_wvalid_i  in  1  LSU write data valid
- lsu_wready_o  out  1  W accept to LSU
- lsu_bvalid_o  out  1  write response valid to LSU
- lsu_bready_i  in  1  LSU ready for write response
- mem_araddr_o  out  ADDR_WIDTH  muxed read address
- mem_arvalid_o  out  1  read request to memory
- mem_arready_i  in  1  memory AR accept
- mem_rvalid_i  in  1  memory read data valid
- mem_rready_o  out  1  steered read ready
- mem_awvalid_o  out  1  gated LSU awvalid
- mem_awready_i  in  1  memory AW accept
- mem_wvalid_o  out  1  gated LSU wvalid
- mem_wready_i  in  1  memory W accept
- mem_bvalid_i  in  1  memory write response valid
- mem_bready_o  out  1  gated LSU bready

Behaviour:
- States: IDLE, IF_AR, IF_R, LS_AR, LS_R, LS_W, LS_B. State is registered. All outputs are combinational from the state plus the owner's and memory's inputs.
- IDLE drives every valid/ready output and mem_araddr_o to 0.
- Requests sampled in IDLE:
  - IFU request: ifu_arvalid_i.
  - LSU write request: lsu_awvalid_i | lsu_wvalid_i.
  - LSU read request: lsu_arvalid_i.
  - Within the LSU, a write beats a read.
- Tie between IFU and LSU: the master not granted last wins (round-robin, last_q). last_q updates on leaving IDLE. Reset value of last_q is the opposite of RESET_PRIO.
- Grant latency: a request present in IDLE at cycle N gives mem-side valid in cycle N+1. There is no combinational IDLE bypass.
- IF_AR / LS_AR:
  - mem_araddr_o = owner araddr; mem_arvalid_o = owner arvalid; owner arready = mem_arready_i.
  - Goes to IF_R / LS_R on the AR handshake.
- IF_R / LS_R:
  - owner rvalid = mem_rvalid_i; mem_rready_o = owner rready.
  - Goes to IDLE on the R handshake.
- LS_W:
  - AW and W are forwarded independently. Flags aw_done_q and w_done_q latch each handshake, and the completed channel's valid is masked afterwards.
  - Goes to LS_B when both are complete, including both completing in the same cycle. Both flags clear on exit.
- LS_B: lsu_bvalid_o = mem_bvalid_i; mem_bready_o = lsu_bready_i. Goes to IDLE on the B handshake.
- The non-owner master always sees arready/awready/wready/rvalid/bvalid = 0. It must hold its request (AXI rule) until granted.
- Transactions are never aborted. An IFU flush does not cancel a granted read; the IFU consumes and discards the data itself.
- Back-to-back: after a response handshake, the next grant takes effect one IDLE cycle later. Minimum 3-cycle occupancy per read when memory is zero-wait.
- rst_i in any state: next cycle state=IDLE, flags=0, last_q=reset value, all outputs 0. The memory is reset by the same rst_i.

Test Plan:
- IFU-only read of 0x80000000 with mem arready/rvalid asserted one cycle after arvalid -> mem_araddr_o=0x80000000 from cycle 1, ifu_rvalid_o pulses once, lsu_* outputs remain 0.
- IFU and LSU read together at reset, RESET_PRIO=0 -> IFU served first. Both re-request immediately -> LSU served next, then IFU again (strict alternation over 6 transactions).
- LSU asserts awvalid and arvalid together -> write (LS_W, LS_B) completes before the read is granted. No mem_arvalid_o during the write.
- LS_W with mem_awready_i at cycle 1 and mem_wready_i at cycle 3 -> mem_awvalid_o drops after cycle 1, mem_wvalid_o is held until cycle 3, LS_B is entered at cycle 4. Repeat with both readies in the same cycle -> direct entry to LS_B.
- IFU stalls by holding ifu_rready_i=0 for 5 cycles while mem_rvalid_i=1 -> mem_rready_o=0 and the state stays IF_R. The pending LSU request is not granted until the R handshake.
- rst_i asserted in LS_B -> next cycle all outputs 0, state IDLE. The first post-reset tie goes to the RESET_PRIO owner.

Source files
------------

// File: rtl/pipe_axi_arbiter.sv
// pipe_axi_arbiter: shares one AXI-Lite memory port between the IFU (read-only)
// and the LSU (read/write). One transaction is in flight at a time. Only the
// handshakes and the read address pass through here; rdata, awaddr, wdata and
// wstrb are wired directly at the top level.
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   ifu_ar*/ifu_r*                   IFU read channels (AR in, R handshake)
//   lsu_ar*/lsu_r*                   LSU read channels
//   lsu_aw*/lsu_w*/lsu_b*            LSU write channels (handshakes only)
//   mem_*                            shared memory-side handshakes + araddr
module pipe_axi_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter bit          RESET_PRIO = 1'b0  // first tie winner: 0=IFU, 1=LSU
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] ifu_araddr_i,
    input  logic                  ifu_arvalid_i,
    output logic                  ifu_arready_o,
    output logic                  ifu_rvalid_o,
    input  logic                  ifu_rready_i,
    input  logic [ADDR_WIDTH-1:0] lsu_araddr_i,
    input  logic                  lsu_arvalid_i,
    output logic                  lsu_arready_o,
    output logic                  lsu_rvalid_o,
    input  logic                  lsu_rready_i,
    input  logic                  lsu_awvalid_i,
    output logic                  lsu_awready_o,
    input  logic                  lsu_wvalid_i,
    output logic                  lsu_wready_o,
    output logic                  lsu_bvalid_o,
    input  logic                  lsu_bready_i,
    output logic [ADDR_WIDTH-1:0] mem_araddr_o,
    output logic                  mem_arvalid_o,
    input  logic                  mem_arready_i,
    input  logic                  mem_rvalid_i,
    output logic                  mem_rready_o,
    output logic                  mem_awvalid_o,
    input  logic                  mem_awready_i,
    output logic                  mem_wvalid_o,
    input  logic                  mem_wready_i,
    input  logic                  mem_bvalid_i,
    output logic                  mem_bready_o
);

    typedef enum logic [2:0] {
        StIdle, StIfAr, StIfR, StLsAr, StLsR, StLsW, StLsB
    } state_e;

    state_e r_state, w_state_next;
    logic   r_last, w_last_next;        // master granted last: 0=IFU, 1=LSU
    logic   r_aw_done, w_aw_done_next;
    logic   r_w_done, w_w_done_next;

    logic w_lsu_wr_req, w_lsu_req, w_grant_lsu;
    logic w_aw_fire, w_w_fire, w_aw_ok, w_w_ok;

    assign w_lsu_wr_req = lsu_awvalid_i | lsu_wvalid_i;
    assign w_lsu_req    = w_lsu_wr_req | lsu_arvalid_i;
    // On a tie the LSU wins only if the IFU was granted last.
    assign w_grant_lsu  = w_lsu_req & (~ifu_arvalid_i | ~r_last);

    assign w_aw_fire = (r_state == StLsW) & lsu_awvalid_i & ~r_aw_done & mem_awready_i;
    assign w_w_fire  = (r_state == StLsW) & lsu_wvalid_i & ~r_w_done & mem_wready_i;
    assign w_aw_ok   = r_aw_done | w_aw_fire;
    assign w_w_ok    = r_w_done | w_w_fire;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_last    <= ~RESET_PRIO;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_last    <= w_last_next;
            r_aw_done <= w_aw_done_next;
            r_w_done  <= w_w_done_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next   = r_state;
        w_last_next    = r_last;
        w_aw_done_next = r_aw_done;
        w_w_done_next  = r_w_done;
        unique case (r_state)
            StIdle: begin
                if (w_grant_lsu) begin
                    w_state_next = w_lsu_wr_req ? StLsW : StLsAr;
                    w_last_next  = 1'b1;
                end else if (ifu_arvalid_i) begin
                    w_state_next = StIfAr;
                    w_last_next  = 1'b0;
                end
            end
            StIfAr: if (ifu_arvalid_i && mem_arready_i) w_state_next = StIfR;
            StIfR:  if (mem_rvalid_i && ifu_rready_i) w_state_next = StIdle;
            StLsAr: if (lsu_arvalid_i && mem_arready_i) w_state_next = StLsR;
            StLsR:  if (mem_rvalid_i && lsu_rready_i) w_state_next = StIdle;
            StLsW: begin
                if (w_aw_ok && w_w_ok) begin
                    w_state_next   = StLsB;
                    w_aw_done_next = 1'b0;
                    w_w_done_next  = 1'b0;
                end else begin
                    w_aw_done_next = w_aw_ok;
                    w_w_done_next  = w_w_ok;
                end
            end
            StLsB:  if (mem_bvalid_i && lsu_bready_i) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Output logic: only the owner sees the memory-side handshakes
    always_comb begin
        ifu_arready_o = 1'b0;
        ifu_rvalid_o  = 1'b0;
        lsu_arready_o = 1'b0;
        lsu_rvalid_o  = 1'b0;
        lsu_awready_o = 1'b0;
        lsu_wready_o  = 1'b0;
        lsu_bvalid_o  = 1'b0;
        mem_araddr_o  = '0;
        mem_arvalid_o = 1'b0;
        mem_rready_o  = 1'b0;
        mem_awvalid_o = 1'b0;
        mem_wvalid_o  = 1'b0;
        mem_bready_o  = 1'b0;
        unique case (r_state)
            StIfAr: begin
                mem_araddr_o  = ifu_araddr_i;
                mem_arvalid_o = ifu_arvalid_i;
                ifu_arready_o = mem_arready_i;
            end
            StIfR: begin
                ifu_rvalid_o = mem_rvalid_i;
                mem_rready_o = ifu_rready_i;
            end
            StLsAr: begin
                mem_araddr_o  = lsu_araddr_i;
                mem_arvalid_o = lsu_arvalid_i;
                lsu_arready_o = mem_arready_i;
            end
            StLsR: begin
                lsu_rvalid_o = mem_rvalid_i;
                mem_rready_o = lsu_rready_i;
            end
            StLsW: begin
                // A channel that already handshook is masked until the next write
                mem_awvalid_o = lsu_awvalid_i & ~r_aw_done;
                lsu_awready_o = mem_awready_i & ~r_aw_done;
                mem_wvalid_o  = lsu_wvalid_i & ~r_w_done;
                lsu_wready_o  = mem_wready_i & ~r_w_done;
            end
            StLsB: begin
                lsu_bvalid_o = mem_bvalid_i;
                mem_bready_o = lsu_bready_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pipe_axi_arbiter.sv
// Directed bench for pipe_axi_arbiter: a cycle-by-cycle vector table covering
// reads, writes, stalls and resets, plus a hand-written round-robin sequence.
module tb_pipe_axi_arbiter;

    localparam int unsigned AW = 32;
    localparam logic [AW-1:0] IFU_ADDR = 32'h8000_0000;
    localparam logic [AW-1:0] LSU_ADDR = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst;
    logic [AW-1:0] ifu_araddr, lsu_araddr, mem_araddr;
    logic ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
    logic mem_arvalid, mem_arready, mem_rvalid, mem_rready;
    logic mem_awvalid, mem_awready, mem_wvalid, mem_wready, mem_bvalid, mem_bready;

    always #5 clk = ~clk;

    pipe_axi_arbiter #(.ADDR_WIDTH(AW), .RESET_PRIO(1'b0)) dut (
        .clk_i(clk), .rst_i(rst),
        .ifu_araddr_i(ifu_araddr), .ifu_arvalid_i(ifu_arvalid), .ifu_arready_o(ifu_arready),
        .ifu_rvalid_o(ifu_rvalid), .ifu_rready_i(ifu_rready),
        .lsu_araddr_i(lsu_araddr), .lsu_arvalid_i(lsu_arvalid), .lsu_arready_o(lsu_arready),
        .lsu_rvalid_o(lsu_rvalid), .lsu_rready_i(lsu_rready),
        .lsu_awvalid_i(lsu_awvalid), .lsu_awready_o(lsu_awready),
        .lsu_wvalid_i(lsu_wvalid), .lsu_wready_o(lsu_wready),
        .lsu_bvalid_o(lsu_bvalid), .lsu_bready_i(lsu_bready),
        .mem_araddr_o(mem_araddr), .mem_arvalid_o(mem_arvalid), .mem_arready_i(mem_arready),
        .mem_rvalid_i(mem_rvalid), .mem_rready_o(mem_rready),
        .mem_awvalid_o(mem_awvalid), .mem_awready_i(mem_awready),
        .mem_wvalid_o(mem_wvalid), .mem_wready_i(mem_wready),
        .mem_bvalid_i(mem_bvalid), .mem_bready_o(mem_bready)
    );

    // in : rst | i_arv i_rr | l_arv l_rr l_awv l_wv l_br | m_arr m_rv m_awr m_wr m_bv
    // exp: i_arr i_rv | l_arr l_rv l_awr l_wr l_bv | m_arv m_rr m_awv m_wv m_br
    // asel: expected mem_araddr_o, 0 = zero, 1 = IFU address, 2 = LSU address
    typedef struct {
        logic [12:0] in;
        logic [11:0] exp;
        logic [1:0]  asel;
    } vec_t;

    localparam int NV = 43;
    vec_t vecs[NV];
    int tests = 0;
    int fails = 0;

    task automatic drive(input logic [12:0] v);
        {rst, ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready, lsu_awvalid, lsu_wvalid,
         lsu_bready, mem_arready, mem_rvalid, mem_awready, mem_wready, mem_bvalid} = v;
    endtask

    initial begin
        logic [11:0]   act;
        logic [AW-1:0] exp_addr;
        int            g_cyc[$];
        logic          g_lsu[$];
        logic [AW-1:0] g_addr[$];

        ifu_araddr = IFU_ADDR;
        lsu_araddr = LSU_ADDR;
        drive(13'b1_00_00000_00000);

        // reset idle
        vecs[0]  = '{13'b1_00_00000_00000, 12'b00_00000_00000, 2'd0};
        // IFU-only read
        vecs[1]  = '{13'b0_11_00000_00000, 12'b00_00000_00000, 2'd0};
        vecs[2]  = '{13'b0_11_00000_10000, 12'b10_00000_10000, 2'd1};
        vecs[3]  = '{13'b0_01_00000_01000, 12'b01_00000_01000, 2'd0};
        vecs[4]  = '{13'b0_00_00000_00000, 12'b00_00000_00000, 2'd0};
        // LSU aw+w+ar together: write first, AW at cycle 1, W at cycle 3
        vecs[5]  = '{13'b0_00_10111_00000, 12'b00_00000_00000, 2'd0};
        vecs[6]  = '{13'b0_00_10111_00100, 12'b00_00100_00110, 2'd0};
        vecs[7]  = '{13'b0_00_10111_00100, 12'b00_00000_00010, 2'd0};
        vecs[8]  = '{13'b0_00_10111_00010, 12'b00_00010_00010, 2'd0};
        vecs[9]  = '{13'b0_00_10001_00001, 12'b00_00001_00001, 2'd0};
        vecs[10] = '{13'b0_00_11000_00000, 12'b00_00000_00000, 2'd0};
        vecs[11] = '{13'b0_00_11000_10000, 12'b00_10000_10000, 2'd2};
        vecs[12] = '{13'b0_00_01000_01000, 12'b00_01000_01000, 2'd0};
        // AW and W in the same cycle, B delayed one cycle
        vecs[13] = '{13'b0_00_00111_00000, 12'b00_00000_00000, 2'd0};
        vecs[14] = '{13'b0_00_00111_00110, 12'b00_00110_00110, 2'd0};
        vecs[15] = '{13'b0_00_00001_00000, 12'b00_00000_00001, 2'd0};
        vecs[16] = '{13'b0_00_00001_00001, 12'b00_00001_00001, 2'd0};
        // tie (IFU wins), IFU stalls R for 5 cycles with LSU pending
        vecs[17] = '{13'b0_10_10000_00000, 12'b00_00000_00000, 2'd0};
        vecs[18] = '{13'b0_10_10000_10000, 12'b10_00000_10000, 2'd1};
        vecs[19] = '{13'b0_00_10000_01000, 12'b01_00000_00000, 2'd0};
        vecs[20] = '{13'b0_00_10000_01000, 12'b01_00000_00000, 2'd0};
        vecs[21] = '{13'b0_00_10000_01000, 12'b01_00000_00000, 2'd0};
        vecs[22] = '{13'b0_00_10000_01000, 12'b01_00000_00000, 2'd0};
        vecs[23] = '{13'b0_00_10000_01000, 12'b01_00000_00000, 2'd0};
        vecs[24] = '{13'b0_01_10000_01000, 12'b01_00000_01000, 2'd0};
        vecs[25] = '{13'b0_00_10000_00000, 12'b00_00000_00000, 2'd0};
        vecs[26] = '{13'b0_00_10000_00000, 12'b00_00000_10000, 2'd2};
        vecs[27] = '{13'b0_00_10000_10000, 12'b00_10000_10000, 2'd2};
        vecs[28] = '{13'b0_00_01000_01000, 12'b00_01000_01000, 2'd0};
        // reset while in LS_B
        vecs[29] = '{13'b0_00_00110_00000, 12'b00_00000_00000, 2'd0};
        vecs[30] = '{13'b0_00_00110_00110, 12'b00_00110_00110, 2'd0};
        vecs[31] = '{13'b1_00_00001_00000, 12'b00_00000_00001, 2'd0};
        vecs[32] = '{13'b0_00_00001_00001, 12'b00_00000_00000, 2'd0};
        // IFU granted last, reset, then a tie must go to IFU again
        vecs[33] = '{13'b0_11_00000_00000, 12'b00_00000_00000, 2'd0};
        vecs[34] = '{13'b0_11_00000_10000, 12'b10_00000_10000, 2'd1};
        vecs[35] = '{13'b1_01_00000_00000, 12'b00_00000_01000, 2'd0};
        vecs[36] = '{13'b0_11_10000_00000, 12'b00_00000_00000, 2'd0};
        vecs[37] = '{13'b0_11_10000_00000, 12'b00_00000_10000, 2'd1};
        vecs[38] = '{13'b0_11_10000_10000, 12'b10_00000_10000, 2'd1};
        vecs[39] = '{13'b0_01_10000_01000, 12'b01_00000_01000, 2'd0};
        vecs[40] = '{13'b0_00_11000_00000, 12'b00_00000_00000, 2'd0};
        vecs[41] = '{13'b0_00_11000_10000, 12'b00_10000_10000, 2'd2};
        vecs[42] = '{13'b0_00_01000_01000, 12'b00_01000_01000, 2'd0};

        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1 drive(vecs[i].in);
            @(negedge clk);
            act = {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready,
                   lsu_bvalid, mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_bready};
            case (vecs[i].asel)
                2'd1:    exp_addr = IFU_ADDR;
                2'd2:    exp_addr = LSU_ADDR;
                default: exp_addr = '0;
            endcase
            tests++;
            if (act !== vecs[i].exp || mem_araddr !== exp_addr) begin
                fails++;
                $display("FAIL vec%0d: outputs %b addr %h, required %b addr %h",
                         i, act, mem_araddr, vecs[i].exp, exp_addr);
            end
        end

        // Round-robin: both masters request continuously after reset, zero-wait memory
        @(posedge clk);
        #1 drive(13'b1_00_00000_00000);
        @(posedge clk);
        #1 drive(13'b0_11_11000_11000);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_arvalid) begin
                g_cyc.push_back(c);
                g_lsu.push_back(lsu_arready);
                g_addr.push_back(mem_araddr);
            end
        end
        for (int t = 0; t < 6; t++) begin
            tests++;
            if (t >= g_cyc.size()) begin
                fails++;
                $display("FAIL rr_grant%0d: got %0d grants, required at least %0d",
                         t, g_cyc.size(), t + 1);
            end else begin
                if (g_lsu[t] !== t[0] || g_addr[t] !== (t[0] ? LSU_ADDR : IFU_ADDR)) begin
                    fails++;
                    $display("FAIL rr_owner%0d: lsu %b addr %h, required lsu %b addr %h",
                             t, g_lsu[t], g_addr[t], t[0], t[0] ? LSU_ADDR : IFU_ADDR);
                end
                if (t > 0) begin
                    tests++;
                    if (g_cyc[t] - g_cyc[t-1] != 3) begin
                        fails++;
                        $display("FAIL rr_gap%0d: %0d cycles, required 3",
                                 t, g_cyc[t] - g_cyc[t-1]);
                    end
                end
            end
        end
        @(posedge clk);
        #1 drive(13'b0_00_00000_00000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
